// File: rtl/ov7670_capture_ctrl.sv
`timescale 1ns/1ps
// ov7670_capture_ctrl
// Camera capture controller in the OV7670 pixel-clock domain. Pairs the
// 8-bit camera byte stream into 16-bit frame-buffer writes, with
// frame-aligned arming, single-shot or continuous capture, RGB565 or
// YUYV-to-gray output, optional 2:1 decimation in both axes, and sticky
// line/frame geometry error flags.
module ov7670_capture_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              href,
  input  logic              vsync,
  input  logic [7:0]        data,
  input  logic              cap_en,
  input  logic              single_shot,
  input  logic              fmt,
  input  logic              decim,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic              err_line,
  output logic              err_frame,
  output logic [7:0]        frame_cnt
);

  // Byte counter saturates one past a full line so an over-long line is
  // still distinguishable from a correct one; same idea for the line counter.
  localparam int BC_W = $clog2(2*H_ACTIVE+2);
  localparam int LC_W = $clog2(V_ACTIVE+2);
  localparam int XW   = BC_W-1;

  localparam logic [BC_W-1:0] BC_FULL = BC_W'(2*H_ACTIVE);
  localparam logic [BC_W-1:0] BC_MAX  = BC_W'(2*H_ACTIVE+1);
  localparam logic [LC_W-1:0] LC_FULL = LC_W'(V_ACTIVE);
  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(V_ACTIVE+1);
  localparam logic [XW-1:0]   X_LIM   = XW'(H_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_ACTIVE
  } state_t;

  state_t state, state_nxt;

  // Input history for edge detection
  logic vsync_q, href_q;
  logic frame_begin, frame_end, line_end;

  // Per-frame configuration, frozen at frame start
  logic fmt_l, decim_l, ss_l;

  // Geometry tracking and pixel assembly
  logic [BC_W-1:0]   byte_cnt;
  logic [LC_W-1:0]   line_cnt;
  logic [ADDR_W-1:0] wptr;
  logic [7:0]        hold;

  // Decoded per-cycle events
  logic start_evt, end_evt, capture_byte, line_evt;

  // Derived datapath values
  logic [XW-1:0]   pix_x;
  logic            x_in, y_in, keep, wr_pix;
  logic [15:0]     pixel;
  logic [BC_W-1:0] byte_inc;
  logic [LC_W-1:0] line_inc, lines_at_end;

  assign frame_begin = vsync_q & ~vsync;
  assign frame_end   = ~vsync_q & vsync;
  assign line_end    = href_q & ~href;

  // Register previous-cycle vsync/href for edge detection.
  // NOTE: clocked state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; = here would create ordering races.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
    end
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: arm on enable, start on frame begin, never abort mid-frame.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cap_en) state_nxt = S_ARM;
      S_ARM: begin
        if (!cap_en)          state_nxt = S_IDLE;
        else if (frame_begin) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: if (frame_end) state_nxt = (ss_l || !cap_en) ? S_IDLE : S_ARM;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: events that steer the datapath this cycle.
  always_comb begin
    start_evt    = 1'b0;
    end_evt      = 1'b0;
    capture_byte = 1'b0;
    line_evt     = 1'b0;
    case (state)
      S_ARM:    start_evt = cap_en & frame_begin;
      S_ACTIVE: begin
        end_evt      = frame_end;
        // Frame end wins over href: a byte arriving with it is dropped.
        capture_byte = href & ~frame_end;
        line_evt     = line_end;
      end
      default:  ;
    endcase
  end

  assign pix_x    = byte_cnt[BC_W-1:1];
  assign x_in     = pix_x < X_LIM;
  assign y_in     = line_cnt < LC_FULL;
  assign keep     = ~decim_l | (~pix_x[0] & ~line_cnt[0]);
  assign wr_pix   = capture_byte & byte_cnt[0] & x_in & y_in & keep;
  assign pixel    = fmt_l ? {hold[7:3], hold[7:2], hold[7:3]} : {hold, data};
  assign byte_inc = (byte_cnt == BC_MAX) ? byte_cnt : byte_cnt + BC_W'(1);
  assign line_inc = (line_cnt == LC_MAX) ? line_cnt : line_cnt + LC_W'(1);
  // A line closing on the same edge as the frame is counted before the check.
  assign lines_at_end = line_evt ? line_inc : line_cnt;

  // Status outputs: one-cycle frame pulses, busy, frame counter.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_start <= start_evt;
      frame_done  <= end_evt;
      busy        <= (state_nxt != S_IDLE);
      if (end_evt) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Latch per-frame configuration when a capture frame starts.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      fmt_l   <= 1'b0;
      decim_l <= 1'b0;
      ss_l    <= 1'b0;
    end else if (start_evt) begin
      fmt_l   <= fmt;
      decim_l <= decim;
      ss_l    <= single_shot;
    end
  end

  // Byte/line counters and the even-byte hold register.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      hold     <= 8'd0;
    end else if (start_evt) begin
      byte_cnt <= '0;
      line_cnt <= '0;
    end else begin
      if (capture_byte) begin
        byte_cnt <= byte_inc;
        if (!byte_cnt[0]) hold <= data;
      end
      // href is low on a line end, so this never collides with a capture.
      if (line_evt) begin
        byte_cnt <= '0;
        line_cnt <= line_inc;
      end
    end
  end

  // Frame-buffer write port: registered strobe, address and data.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      we    <= 1'b0;
      wAddr <= '0;
      wData <= 16'd0;
      wptr  <= '0;
    end else begin
      we <= wr_pix;
      if (start_evt) begin
        wptr <= '0;
      end else if (wr_pix) begin
        wAddr <= wptr;
        wData <= pixel;
        wptr  <= wptr + ADDR_W'(1);
      end
    end
  end

  // Sticky geometry errors, cleared only when a new capture frame starts.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else if (start_evt) begin
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      if (line_evt && byte_cnt != BC_FULL)     err_line  <= 1'b1;
      if (end_evt && lines_at_end != LC_FULL) err_frame <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
`timescale 1ns/1ps
// tb_ov7670_capture_ctrl
// Directed bench for the capture controller with a 4x3 frame. Expected
// writes are queued as each frame is driven and compared as the DUT
// strobes we; status outputs are checked at fixed points in the sequence.
module tb_ov7670_capture_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  logic          pclk = 1'b0;
  logic          reset = 1'b0;
  logic          href = 1'b0;
  logic          vsync = 1'b1;
  logic [7:0]    data = 8'd0;
  logic          cap_en = 1'b0;
  logic          single_shot = 1'b0;
  logic          fmt = 1'b0;
  logic          decim = 1'b0;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [15:0]   wData;
  logic          frame_start, frame_done, busy, err_line, err_frame;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  logic [19:0] sb [$];
  logic [19:0] mon_exp;
  logic [7:0]  line_buf [0:7];

  ov7670_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .data(data),
    .cap_en(cap_en), .single_shot(single_shot), .fmt(fmt), .decim(decim),
    .we(we), .wAddr(wAddr), .wData(wData), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy), .err_line(err_line),
    .err_frame(err_frame), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Write monitor: every strobe must match the next queued expectation.
  always @(negedge pclk) begin
    if (frame_done === 1'b1) done_pulses++;
    if (we === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr=%0h data=%h, expected no write", wAddr, wData);
      end
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        checks++;
        assert ({wAddr, wData} === mon_exp) else begin
          errors++;
          $error("FAIL write: observed addr=%0h data=%h, expected addr=%0h data=%h",
                 wAddr, wData, mon_exp[19:16], mon_exp[15:0]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gray16(input logic [7:0] y);
    return {y[7:3], y[7:2], y[7:3]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    data = b;
    @(negedge pclk);
  endtask

  task automatic end_line();
    href = 1'b0;
    data = 8'd0;
    cyc(3);
  endtask

  task automatic send_buf(input int n);
    for (int i = 0; i < n; i++) send_byte(line_buf[i]);
    end_line();
  endtask

  task automatic fill_seq(input logic [7:0] base);
    for (int i = 0; i < 8; i++) line_buf[i] = base + 8'(i);
  endtask

  task automatic send_seq_line(input logic [7:0] base);
    fill_seq(base);
    send_buf(8);
  endtask

  task automatic exp_wr(input int a, input logic [15:0] d);
    sb.push_back({4'(a), d});
  endtask

  // Queue a full undecimated RGB565 frame whose lines carry incrementing bytes.
  task automatic exp_rgb_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] base [0:2];
    logic [7:0] hi, lo;
    base[0] = b0; base[1] = b1; base[2] = b2;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        hi = base[y] + 8'(2*x);
        lo = hi + 8'd1;
        exp_wr(y*H + x, {hi, lo});
      end
  endtask

  task automatic frame_begin();
    vsync = 1'b0;
    @(negedge pclk);
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    @(negedge pclk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".we"},          32'(we), 32'd0);
    check({tag, ".wAddr"},       32'(wAddr), 32'd0);
    check({tag, ".wData"},       32'(wData), 32'd0);
    check({tag, ".frame_start"}, 32'(frame_start), 32'd0);
    check({tag, ".frame_done"},  32'(frame_done), 32'd0);
    check({tag, ".busy"},        32'(busy), 32'd0);
    check({tag, ".err_line"},    32'(err_line), 32'd0);
    check({tag, ".err_frame"},   32'(err_frame), 32'd0);
    check({tag, ".frame_cnt"},   32'(frame_cnt), 32'd0);
  endtask

  initial begin
    // Reset values
    cyc(2);
    check_all_zero("reset");
    reset  = 1'b1;
    cap_en = 1'b1;
    cyc(1);
    check("arm_busy", 32'(busy), 32'd1);
    cyc(2);

    // RGB565 frame, continuous mode
    exp_rgb_frame(8'h00, 8'h08, 8'h10);
    frame_begin();
    check("rgb_frame_start", 32'(frame_start), 32'd1);
    cyc(1);
    check("rgb_frame_start_pulse", 32'(frame_start), 32'd0);
    cyc(1);
    send_byte(8'h00);
    send_byte(8'h01);
    check("latency_we", 32'(we), 32'd1);
    check("latency_addr", 32'(wAddr), 32'd0);
    check("latency_data", 32'(wData), 32'h0001);
    send_byte(8'h02);
    check("we_one_cycle", 32'(we), 32'd0);
    for (int i = 3; i < 8; i++) send_byte(8'(i));
    end_line();
    send_seq_line(8'h08);
    send_seq_line(8'h10);
    frame_end();
    check("rgb_frame_done", 32'(frame_done), 32'd1);
    check("rgb_frame_cnt", 32'(frame_cnt), 32'd1);
    check("rgb_busy", 32'(busy), 32'd1);
    check("rgb_err_line", 32'(err_line), 32'd0);
    check("rgb_err_frame", 32'(err_frame), 32'd0);
    cyc(1);
    check("rgb_frame_done_pulse", 32'(frame_done), 32'd0);
    cyc(2);
    check("rgb_all_written", 32'(sb.size()), 32'd0);

    // Decimation: even pixels of even lines only
    decim = 1'b1;
    exp_wr(0, 16'h0001);
    exp_wr(1, 16'h0405);
    exp_wr(2, 16'h1011);
    exp_wr(3, 16'h1415);
    frame_begin();
    cyc(2);
    send_seq_line(8'h00);
    send_seq_line(8'h08);
    send_seq_line(8'h10);
    frame_end();
    check("decim_frame_cnt", 32'(frame_cnt), 32'd2);
    cyc(3);
    check("decim_all_written", 32'(sb.size()), 32'd0);

    // Geometry errors: short line 1, only two lines
    decim = 1'b0;
    for (int x = 0; x < 4; x++) exp_wr(x, {8'h50 + 8'(2*x), 8'h51 + 8'(2*x)});
    for (int x = 0; x < 3; x++) exp_wr(4 + x, {8'h60 + 8'(2*x), 8'h61 + 8'(2*x)});
    frame_begin();
    cyc(2);
    send_seq_line(8'h50);
    check("geo_err_line_ok", 32'(err_line), 32'd0);
    fill_seq(8'h60);
    send_buf(6);
    check("geo_err_line_set", 32'(err_line), 32'd1);
    check("geo_err_frame_pre", 32'(err_frame), 32'd0);
    frame_end();
    check("geo_frame_done", 32'(frame_done), 32'd1);
    check("geo_err_frame_set", 32'(err_frame), 32'd1);
    check("geo_frame_cnt", 32'(frame_cnt), 32'd3);
    cyc(3);
    check("geo_err_line_sticky", 32'(err_line), 32'd1);
    check("geo_all_written", 32'(sb.size()), 32'd0);

    // Gray output; also confirms error flags clear at frame start
    fmt = 1'b1;
    line_buf[0] = 8'hFF; line_buf[1] = 8'h80; line_buf[2] = 8'h80; line_buf[3] = 8'h12;
    line_buf[4] = 8'h10; line_buf[5] = 8'h20; line_buf[6] = 8'hF8; line_buf[7] = 8'h00;
    exp_wr(0, 16'hFFFF);
    exp_wr(1, 16'h8410);
    exp_wr(2, gray16(8'h10));
    exp_wr(3, gray16(8'hF8));
    for (int x = 0; x < 4; x++) exp_wr(4 + x, gray16(8'h40 + 8'(2*x)));
    for (int x = 0; x < 4; x++) exp_wr(8 + x, gray16(8'h90 + 8'(2*x)));
    frame_begin();
    check("gray_frame_start", 32'(frame_start), 32'd1);
    check("clear_err_line", 32'(err_line), 32'd0);
    check("clear_err_frame", 32'(err_frame), 32'd0);
    cyc(2);
    send_buf(8);
    send_seq_line(8'h40);
    send_seq_line(8'h90);
    frame_end();
    check("gray_frame_cnt", 32'(frame_cnt), 32'd4);
    check("gray_err_frame", 32'(err_frame), 32'd0);
    cyc(3);
    check("gray_all_written", 32'(sb.size()), 32'd0);

    // Arm mid-frame: nothing captured until the next frame begin
    fmt = 1'b0;
    cap_en = 1'b0;
    cyc(2);
    check("disarm_busy", 32'(busy), 32'd0);
    frame_begin();
    check("idle_no_start", 32'(frame_start), 32'd0);
    cyc(1);
    send_byte(8'h30);
    send_byte(8'h31);
    cap_en = 1'b1;
    for (int i = 2; i < 8; i++) send_byte(8'h30 + 8'(i));
    end_line();
    check("midframe_arm_busy", 32'(busy), 32'd1);
    send_seq_line(8'h38);
    frame_end();
    check("midframe_no_done", 32'(frame_done), 32'd0);
    check("midframe_frame_cnt", 32'(frame_cnt), 32'd4);
    cyc(3);

    // Single shot: one frame, busy drops with frame_done
    single_shot = 1'b1;
    exp_rgb_frame(8'h00, 8'h08, 8'h10);
    frame_begin();
    check("ss_frame_start", 32'(frame_start), 32'd1);
    cyc(2);
    send_seq_line(8'h00);
    send_seq_line(8'h08);
    send_seq_line(8'h10);
    frame_end();
    check("ss_frame_done", 32'(frame_done), 32'd1);
    check("ss_busy_low", 32'(busy), 32'd0);
    check("ss_frame_cnt", 32'(frame_cnt), 32'd5);
    cap_en = 1'b0;
    cyc(3);
    check("ss_all_written", 32'(sb.size()), 32'd0);
    frame_begin();
    check("ss_next_no_start", 32'(frame_start), 32'd0);
    cyc(2);
    send_seq_line(8'hA0);
    send_seq_line(8'hA8);
    send_seq_line(8'hB0);
    frame_end();
    check("ss_next_no_done", 32'(frame_done), 32'd0);
    check("ss_next_frame_cnt", 32'(frame_cnt), 32'd5);
    check("ss_next_busy", 32'(busy), 32'd0);
    cyc(3);

    // Asynchronous reset in the middle of an active line
    single_shot = 1'b0;
    cap_en = 1'b1;
    cyc(2);
    exp_wr(0, 16'h2021);
    exp_wr(1, 16'h2223);
    frame_begin();
    cyc(2);
    for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
    href = 1'b1;
    data = 8'h24;
    @(posedge pclk);
    #2 reset = 1'b0;
    #1 check_all_zero("midline_reset");
    @(negedge pclk);
    reset = 1'b1;
    for (int i = 5; i < 8; i++) send_byte(8'h20 + 8'(i));
    end_line();
    check("post_reset_busy", 32'(busy), 32'd1);
    send_seq_line(8'h70);
    frame_end();
    check("post_reset_no_done", 32'(frame_done), 32'd0);
    check("post_reset_frame_cnt0", 32'(frame_cnt), 32'd0);
    cyc(2);
    check("post_reset_drained", 32'(sb.size()), 32'd0);
    exp_rgb_frame(8'h80, 8'h88, 8'h90);
    frame_begin();
    check("post_reset_frame_start", 32'(frame_start), 32'd1);
    cyc(2);
    send_seq_line(8'h80);
    send_seq_line(8'h88);
    send_seq_line(8'h90);
    frame_end();
    check("post_reset_frame_done", 32'(frame_done), 32'd1);
    check("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);
    check("post_reset_err_line", 32'(err_line), 32'd0);
    check("post_reset_err_frame", 32'(err_frame), 32'd0);
    cyc(3);
    check("post_reset_all_written", 32'(sb.size()), 32'd0);
    check("total_done_pulses", 32'(done_pulses), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_ctrl.md
# ov7670_capture_ctrl

Parametrised camera capture controller on the OV7670 pixel-clock domain. It converts the 8-bit byte stream into 16-bit pixel writes for the frame buffer, with several features:
- frame-aligned arm/start;
- single-shot or continuous capture;
- runtime RGB565 / YUV422-gray selection;
- optional 2:1 decimation in both axes;
- line and frame geometry checking.

It sits between the camera pins and the frame-buffer write port.

## Interface
- H_ACTIVE, 640, active pixels per source line (2 bytes each)
- V_ACTIVE, 480, active lines per source frame
- ADDR_W, 19, frame-buffer address width; must hold H_ACTIVE*V_ACTIVE-1
- pclk  in  1  camera pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- href  in  1  line-valid from camera, high during active bytes
- vsync  in  1  frame sync, high during vertical blanking
- data  in  8  camera byte
- cap_en  in  1  level enable; capture begins only at a frame boundary
- single_shot  in  1  1: stop after one frame; latched at frame start
- fmt  in  1  0: RGB565; 1: YUYV, output gray; latched at frame start
- decim  in  1  1: keep even pixels of even lines only; latched at frame start
- we  out  1  one-cycle write strobe
- wAddr  out  ADDR_W  write address
- wData  out  16  write data
- frame_start  out  1  one-cycle pulse at capture frame start
- frame_done  out  1  one-cycle pulse at capture frame end
- busy  out  1  high in ARM and ACTIVE
- err_line  out  1  sticky: some line had byte count ≠ 2*H_ACTIVE
- err_frame  out  1  sticky: frame line count ≠ V_ACTIVE
- frame_cnt  out  8  completed frames, wraps 255→0

## Operation
- Inputs are synchronous to pclk.
- vsync_q holds the previous-cycle vsync.
  - Frame begin: vsync_q=1 & vsync=0.
  - Frame end: vsync_q=0 & vsync=1.
- Line end: href falls (href_q=1 & href=0).
- States:
  - IDLE → ARM when cap_en=1.
  - ARM → ACTIVE on frame begin. In the same transition:
    - latch fmt/decim/single_shot;
    - clear byte, line and write pointers;
    - clear err_line/err_frame;
    - pulse frame_start.
  - ACTIVE → (frame end):
    - pulse frame_done;
    - frame_cnt+1;
    - set err_frame if line count ≠ V_ACTIVE;
    - next state IDLE if latched single_shot=1 or cap_en=0, else ARM.
  - ARM → IDLE if cap_en drops.
- Deasserting cap_en in ACTIVE does not abort; the current frame completes.
- Byte pairing (ACTIVE, href=1):
  - Even byte index → hold register.
  - Odd byte index → form pixel.
  - RGB565: wData = {byte0, byte1}.
  - Gray: Y = byte0, wData = {Y[7:3], Y[7:2], Y[7:3]}; chroma byte ignored.
- Pixel x = byte index/2; y = line count.
- A pixel is written when x < H_ACTIVE and y < V_ACTIVE, and, if decim=1, x and y are both even.
  - Written pixels use wAddr = write pointer; the pointer then increments (first write at 0).
  - Bytes beyond 2*H_ACTIVE and lines beyond V_ACTIVE are dropped, so the pointer never exceeds H_ACTIVE*V_ACTIVE-1.
- At line end in ACTIVE:
  - set err_line if byte count ≠ 2*H_ACTIVE;
  - line count +1 (saturating at V_ACTIVE+1);
  - byte count → 0.
- A trailing odd byte at line end is discarded.
- Frame end takes precedence over href: a pending half-pixel is discarded.
- If line end and frame end occur in the same cycle, the line is counted before the err_frame check.
- err_line/err_frame hold until the next frame_start or reset.
- Counter widths: byte count $clog2(2*H_ACTIVE+2), line count $clog2(V_ACTIVE+2).

## Timing
- All outputs are registered.
- Reset values: we=0, wAddr=0, wData=0, frame_start=0, frame_done=0, busy=0, err_line=0, err_frame=0, frame_cnt=0; state IDLE.
- Reset takes effect immediately (asynchronous), including mid-line and mid-frame.
- Write latency:
  - The odd byte is sampled on edge N.
  - we=1 with valid wAddr/wData during cycle N+1, for one cycle.
  - Minimum spacing between writes is 2 cycles.
- frame_start is high in the cycle after the edge that sees frame begin; frame_done likewise after frame end.
- busy rises the cycle after cap_en is seen in IDLE. It falls the cycle frame_done is high when returning to IDLE.
- err_line/err_frame update in the cycle after the detecting edge.

## Test plan
Parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=3, ADDR_W=4.
- **RGB565 frame:** cap_en=1, fmt=0, decim=0; vsync falls; 3 lines of 8 bytes 0x00..0x17; vsync rises → 12 writes at addr 0..11, first wData 0x0001, last 0x1617, frame_done one pulse, frame_cnt=1, no errors.
- **Decimation:** same stimulus with decim=1 → 4 writes only: addr 0,1 = 0x0001, 0x0405; addr 2,3 = 0x1011, 0x1415.
- **Gray:** fmt=1, byte pairs (0xFF,0x80) then (0x80,0x12) → wData 0xFFFF then 0x8410.
- **Geometry errors:** line 1 has 6 bytes; only 2 lines are sent before vsync rises → err_line=1 after line 1, err_frame=1 after frame end; both clear at next frame_start.
- **Arm/single-shot:** cap_en raised mid-frame (vsync=0, href active) → no writes until the next vsync fall. With single_shot=1: one frame captured, busy→0 with frame_done, following frame produces no writes.
- **Reset mid-line:** reset low between pclk edges during an active line → all outputs 0 immediately; after release with cap_en=1, capture waits for the next frame begin.
